// File: rtl/times_table_gen.sv
// Multiplication lookup table: after reset it builds every a*b product by
// repeated addition, one entry per clock, then serves lookups with 1-cycle latency.
//
// state | meaning
// FILL  | writing entry {ia,ib} = acc, one per clock, ascending address
// RUN   | table complete and frozen; reads accepted every cycle

module times_table_gen #(
    parameter int WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   result
);

    localparam int RW    = 2 * WIDTH;
    localparam int DEPTH = 2 ** RW;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] ia;
    logic [WIDTH-1:0] ib;
    logic [RW-1:0]    acc;
    logic             fill_en;
    logic             row_end;
    logic [RW-1:0]    tbl_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_en   = 1'b0;
        ready     = 1'b0;
        row_end   = &ib;
        case (state)
            FILL: begin
                fill_en = 1'b1;
                if ((&ia) && (&ib)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // acc tracks ia*ib: it restarts at 0 with each new row and grows by ia per column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ia  <= '0;
            ib  <= '0;
            acc <= '0;
        end else if (fill_en) begin
            ib <= ib + 1'b1;
            if (row_end) begin
                ia  <= ia + 1'b1;
                acc <= '0;
            end else begin
                acc <= acc + {{WIDTH{1'b0}}, ia};
            end
        end
    end

    // Storage has no reset: every entry is rewritten before ready rises
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tbl_mem[{ia, ib}] <= acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            result <= '0;
        end else if (ready && read) begin
            valid  <= 1'b1;
            result <= tbl_mem[{a, b}];
        end else begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: doc/times_table_gen.md
TIMES_TABLE_GEN -- requirements
Module: times_table_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 3, operand width in bits; legal range 2..6.
REQ-002 SHALL use the derived constants DEPTH = 2^(2*WIDTH) (table entries) and RW = 2*WIDTH (result width); these are internal and not overridable.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port read, input, 1, lookup request, sampled on the rising edge.
REQ-006 SHALL have port a, input, WIDTH, first operand, 0..2^WIDTH-1.
REQ-007 SHALL have port b, input, WIDTH, second operand, 0..2^WIDTH-1.
REQ-008 SHALL have port ready, output, 1, high when the table is fully built and lookups are accepted.
REQ-009 SHALL have port valid, output, 1, high for one cycle per accepted lookup.
REQ-010 SHALL have port result, output, RW, product a*b of the accepted lookup.

Function
REQ-011 SHALL hold an internal table of DEPTH entries, each RW bits wide, addressed as a*2^WIDTH + b ({a,b} concatenation).
REQ-012 SHALL build the table itself after reset, with no external initialisation file and no multiplier operator; each product SHALL be formed by repeated addition.
REQ-013 SHALL implement the two-state FSM FILL -> RUN; reset forces FILL; RUN is terminal until the next reset.
REQ-014 In FILL, SHALL write exactly one entry per clock, in ascending address order from 0 to DEPTH-1.
REQ-015 Fill datapath: row counter ia and column counter ib (each WIDTH bits) plus an RW-bit accumulator acc; entry {ia,ib} SHALL be written with acc.
  - acc SHALL equal 0 whenever ib = 0.
  - Each cycle, acc <= acc + ia and ib <= ib + 1.
  - When ib wraps from all-ones to 0: ia <= ia + 1 and acc <= 0.
REQ-016 acc SHALL never overflow RW bits; the maximum entry is (2^WIDTH-1)^2.
REQ-017 The first rising edge after rst deasserts SHALL write address 0; the edge that writes address DEPTH-1 SHALL also move the FSM to RUN and set ready = 1. Ready is therefore high after exactly DEPTH edges.
REQ-018 In FILL, read SHALL be ignored: valid stays 0 and result holds its value.
REQ-019 In RUN, a rising edge with read = 1 SHALL register result <= table[{a,b}] and valid <= 1.
REQ-020 In RUN, read latency SHALL be 1 clock, and back-to-back reads every cycle SHALL be supported at full throughput.
REQ-021 In RUN, a rising edge with read = 0 SHALL set valid <= 0; result SHALL hold its last value.
REQ-022 Operands SHALL be sampled only at the accepting edge; changes to a or b between edges SHALL have no effect.
REQ-023 The table SHALL NOT be writable in RUN; contents SHALL stay constant until the next reset.

Reset
REQ-024 While rst = 1, asynchronously and independently of clk: ready = 0, valid = 0, result = 0, FSM = FILL, ia = ib = 0, acc = 0.
REQ-025 Table contents need not be cleared by reset; every entry SHALL be rewritten by the following FILL before ready rises.
REQ-026 Reset asserted mid-FILL or mid-read SHALL abort the operation at once; after release, a complete fill of DEPTH cycles SHALL restart from address 0.

Verification
REQ-027 Fill timing, WIDTH=3: release rst, read=0 -> ready=0 for edges 1..63, ready=1 after edge 64; valid=0 and result=0 throughout.
REQ-028 Boundary lookups, WIDTH=3, RUN: read=1 with a=7,b=7 -> next cycle valid=1, result=49; then a=0,b=5 -> result=0; then a=5,b=3 -> result=15.
REQ-029 Exhaustive sweep, WIDTH=3: 64 back-to-back reads over all {a,b} -> 64 consecutive valid pulses with result = a*b each, 1-cycle latency; read=0 afterwards -> valid=0, result holds the last value.
REQ-030 Read during FILL: read=1, a=3, b=3 held from reset release -> valid=0 until ready=1; the first valid pulse occurs 1 cycle after ready rises, with result=9.
REQ-031 Mid-operation reset: pulse rst at fill address 20, and separately during a RUN read -> outputs clear immediately; ready rises again exactly 64 edges after release; tables are identical before and after.
REQ-032 Parameter check, WIDTH=4: ready after 256 edges; a=15,b=15 -> result=225 (8-bit); a=15,b=1 -> 15.
